// File: rtl/nf_10g_stats_pkg.sv
// Shared definitions for the 10G MAC statistics collector: counter select
// encoding and the wrap/saturate accumulator add.
package nf_10g_stats_pkg;

  localparam int unsigned CNT_MAX_W = 64;
  localparam int unsigned NUM_CNT   = 5;

  typedef enum logic [2:0] {
    SEL_RX_GOOD_PKTS = 3'd0,
    SEL_RX_BAD_PKTS  = 3'd1,
    SEL_RX_BYTES     = 3'd2,
    SEL_TX_PKTS      = 3'd3,
    SEL_TX_BYTES     = 3'd4
  } cnt_sel_e;

  // Adds within a counter of 'width' bits (<= 64); overflow wraps or pins at all-ones.
  function automatic logic [CNT_MAX_W-1:0] cnt_add(
    input logic [CNT_MAX_W-1:0] a,
    input logic [CNT_MAX_W-1:0] b,
    input int unsigned          width,
    input logic                 sat
  );
    logic [CNT_MAX_W:0] sum;
    logic [CNT_MAX_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((CNT_MAX_W+1)'(1) << width) - (CNT_MAX_W+1)'(1);
    if (sum > lim) begin
      return sat ? lim[CNT_MAX_W-1:0] : (sum[CNT_MAX_W-1:0] & lim[CNT_MAX_W-1:0]);
    end
    return sum[CNT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/nf_rr_arbiter.sv
// Round-robin arbiter: combinational grant, pointer moves to grant+1 on advance.
module nf_rr_arbiter #(
  parameter  int unsigned C_NUM_REQ = 8,
  localparam int unsigned IDX_W     = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1
) (
  input  logic                 core_clk,
  input  logic                 reset,
  input  logic [C_NUM_REQ-1:0] req,
  input  logic                 advance,
  output logic [C_NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]     grant_idx_c,
  output logic                 grant_valid_c
);

  logic [IDX_W-1:0] ptr;

  function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
    return IDX_W'(v % C_NUM_REQ);
  endfunction

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    grant_c       = '0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    for (int unsigned i = 0; i < C_NUM_REQ; i++) begin
      if (!grant_valid_c && req[wrap_idx(32'(ptr) + i)]) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = wrap_idx(32'(ptr) + i);
      end
    end
    if (grant_valid_c) grant_c[grant_idx_c] = 1'b1;
  end

  always_ff @(posedge core_clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && grant_valid_c) begin
      ptr <= wrap_idx(32'(grant_idx_c) + 32'd1);
    end
  end

endmodule

// File: rtl/nf_10g_stats_collector.sv
// Per-port RX/TX packet and byte counters fed by one-deep event capture and a
// round-robin arbiter, with a single-cycle register read port and clear-on-read.
module nf_10g_stats_collector
  import nf_10g_stats_pkg::*;
#(
  parameter int unsigned C_NUM_PORTS      = 4,
  parameter int unsigned C_PKT_CNT_WIDTH  = 32,
  parameter int unsigned C_BYTE_CNT_WIDTH = 48,
  parameter int unsigned C_LEN_WIDTH      = 16,
  parameter int unsigned C_SATURATE       = 0
) (
  input  logic                               core_clk,
  input  logic                               reset,
  input  logic [C_NUM_PORTS-1:0]             rx_evt_valid,
  input  logic [C_NUM_PORTS*C_LEN_WIDTH-1:0] rx_evt_len,
  input  logic [C_NUM_PORTS-1:0]             rx_evt_good,
  input  logic [C_NUM_PORTS-1:0]             tx_evt_valid,
  input  logic [C_NUM_PORTS*C_LEN_WIDTH-1:0] tx_evt_len,
  input  logic                               rd_req,
  input  logic [2:0]                         rd_port,
  input  logic [2:0]                         rd_sel,
  input  logic                               rd_clear,
  output logic                               rd_valid,
  output logic [C_BYTE_CNT_WIDTH-1:0]        rd_data,
  output logic [C_NUM_PORTS-1:0]             evt_overrun,
  input  logic                               overrun_clear
);

  localparam int unsigned NUM_SRC = 2 * C_NUM_PORTS;
  localparam int unsigned SRC_W   = $clog2(NUM_SRC);
  localparam int unsigned PORT_W  = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1;
  localparam int unsigned PW      = C_PKT_CNT_WIDTH;
  localparam int unsigned BW      = C_BYTE_CNT_WIDTH;
  localparam logic        SAT     = (C_SATURATE != 0);

  logic [NUM_SRC-1:0]     src_valid, src_good;
  logic [C_LEN_WIDTH-1:0] src_len  [NUM_SRC];
  logic [NUM_SRC-1:0]     pend, pend_good;
  logic [C_LEN_WIDTH-1:0] pend_len [NUM_SRC];
  logic [NUM_SRC-1:0]     gnt;
  logic [SRC_W-1:0]       gnt_idx;
  logic                   gnt_valid;

  logic [PW-1:0] rx_good_pkts [C_NUM_PORTS];
  logic [PW-1:0] rx_bad_pkts  [C_NUM_PORTS];
  logic [BW-1:0] rx_bytes     [C_NUM_PORTS];
  logic [PW-1:0] tx_pkts      [C_NUM_PORTS];
  logic [BW-1:0] tx_bytes     [C_NUM_PORTS];

  logic [C_NUM_PORTS-1:0] upd_rx_good, upd_rx_bad, upd_tx, ovr_set;
  logic [C_NUM_PORTS-1:0] clr_rx_good, clr_rx_bad, clr_rx_bytes, clr_tx_pkts, clr_tx_bytes;
  logic [PORT_W-1:0]      g_port, rd_pidx;
  logic [C_LEN_WIDTH-1:0] g_len;
  logic                   g_good, g_is_tx;
  logic [BW-1:0]          rd_mux;

  nf_rr_arbiter #(.C_NUM_REQ(NUM_SRC)) u_arb (
    .core_clk      (core_clk),
    .reset         (reset),
    .req           (pend),
    .advance       (1'b1),
    .grant_c       (gnt),
    .grant_idx_c   (gnt_idx),
    .grant_valid_c (gnt_valid)
  );

  function automatic logic [PW-1:0] pkt_next(input logic [PW-1:0] cur, input logic clr,
                                             input logic upd);
    logic [PW-1:0] base;
    base = clr ? '0 : cur;
    if (upd) return PW'(cnt_add(CNT_MAX_W'(base), CNT_MAX_W'(1), PW, SAT));
    return base;
  endfunction

  function automatic logic [BW-1:0] byte_next(input logic [BW-1:0] cur, input logic clr,
                                              input logic upd, input logic [C_LEN_WIDTH-1:0] len);
    logic [BW-1:0] base;
    base = clr ? '0 : cur;
    if (upd) return BW'(cnt_add(CNT_MAX_W'(base), CNT_MAX_W'(len), BW, SAT));
    return base;
  endfunction

  // Flatten RX/TX per port into sources: 2p = RX, 2p+1 = TX.
  always_comb begin
    src_valid = '0;
    src_good  = '0;
    src_len   = '{default: '0};
    for (int unsigned p = 0; p < C_NUM_PORTS; p++) begin
      src_valid[2*p]   = rx_evt_valid[p];
      src_valid[2*p+1] = tx_evt_valid[p];
      src_good[2*p]    = rx_evt_good[p];
      src_good[2*p+1]  = 1'b1;
      src_len[2*p]     = rx_evt_len[p*C_LEN_WIDTH +: C_LEN_WIDTH];
      src_len[2*p+1]   = tx_evt_len[p*C_LEN_WIDTH +: C_LEN_WIDTH];
    end
  end

  assign g_port  = PORT_W'(gnt_idx >> 1);
  assign g_is_tx = gnt_idx[0];
  assign g_len   = pend_len[gnt_idx];
  assign g_good  = pend_good[gnt_idx];
  assign rd_pidx = PORT_W'(rd_port);

  // Per-port update, clear-on-read and overrun qualifiers.
  always_comb begin
    upd_rx_good  = '0;
    upd_rx_bad   = '0;
    upd_tx       = '0;
    ovr_set      = '0;
    clr_rx_good  = '0;
    clr_rx_bad   = '0;
    clr_rx_bytes = '0;
    clr_tx_pkts  = '0;
    clr_tx_bytes = '0;
    for (int unsigned p = 0; p < C_NUM_PORTS; p++) begin
      upd_rx_good[p]  = gnt_valid && (g_port == PORT_W'(p)) && !g_is_tx && g_good;
      upd_rx_bad[p]   = gnt_valid && (g_port == PORT_W'(p)) && !g_is_tx && !g_good;
      upd_tx[p]       = gnt_valid && (g_port == PORT_W'(p)) && g_is_tx;
      ovr_set[p]      = (src_valid[2*p]   && pend[2*p]   && !gnt[2*p]) ||
                        (src_valid[2*p+1] && pend[2*p+1] && !gnt[2*p+1]);
      clr_rx_good[p]  = rd_req && rd_clear && (rd_port == 3'(p)) && (rd_sel == SEL_RX_GOOD_PKTS);
      clr_rx_bad[p]   = rd_req && rd_clear && (rd_port == 3'(p)) && (rd_sel == SEL_RX_BAD_PKTS);
      clr_rx_bytes[p] = rd_req && rd_clear && (rd_port == 3'(p)) && (rd_sel == SEL_RX_BYTES);
      clr_tx_pkts[p]  = rd_req && rd_clear && (rd_port == 3'(p)) && (rd_sel == SEL_TX_PKTS);
      clr_tx_bytes[p] = rd_req && rd_clear && (rd_port == 3'(p)) && (rd_sel == SEL_TX_BYTES);
    end
  end

  always_comb begin
    rd_mux = '0;
    if (32'(rd_port) < C_NUM_PORTS) begin
      case (rd_sel)
        SEL_RX_GOOD_PKTS: rd_mux = BW'(rx_good_pkts[rd_pidx]);
        SEL_RX_BAD_PKTS:  rd_mux = BW'(rx_bad_pkts[rd_pidx]);
        SEL_RX_BYTES:     rd_mux = rx_bytes[rd_pidx];
        SEL_TX_PKTS:      rd_mux = BW'(tx_pkts[rd_pidx]);
        SEL_TX_BYTES:     rd_mux = tx_bytes[rd_pidx];
        default:          rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge core_clk) begin
    if (reset) begin
      pend        <= '0;
      pend_good   <= '0;
      pend_len    <= '{default: '0};
      rx_good_pkts <= '{default: '0};
      rx_bad_pkts  <= '{default: '0};
      rx_bytes     <= '{default: '0};
      tx_pkts      <= '{default: '0};
      tx_bytes     <= '{default: '0};
      evt_overrun <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      // A granted source frees its slot this edge, so a new strobe may reload it.
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        if (src_valid[s] && (!pend[s] || gnt[s])) begin
          pend[s]      <= 1'b1;
          pend_len[s]  <= src_len[s];
          pend_good[s] <= src_good[s];
        end else if (gnt[s]) begin
          pend[s] <= 1'b0;
        end
      end
      for (int unsigned p = 0; p < C_NUM_PORTS; p++) begin
        rx_good_pkts[p] <= pkt_next(rx_good_pkts[p], clr_rx_good[p], upd_rx_good[p]);
        rx_bad_pkts[p]  <= pkt_next(rx_bad_pkts[p], clr_rx_bad[p], upd_rx_bad[p]);
        rx_bytes[p]     <= byte_next(rx_bytes[p], clr_rx_bytes[p], upd_rx_good[p], g_len);
        tx_pkts[p]      <= pkt_next(tx_pkts[p], clr_tx_pkts[p], upd_tx[p]);
        tx_bytes[p]     <= byte_next(tx_bytes[p], clr_tx_bytes[p], upd_tx[p], g_len);
      end
      evt_overrun <= (evt_overrun & ~{C_NUM_PORTS{overrun_clear}}) | ovr_set;
      rd_valid    <= rd_req;
      if (rd_req) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_nf_10g_stats_collector.sv
// Directed bench for nf_10g_stats_collector with a cycle-level reference model
// of the main 4-port instance and two 16-bit instances for wrap/saturate.
module tb_nf_10g_stats_collector;

  localparam int NP = 4;
  localparam int NS = 2 * NP;
  localparam int LW = 16;
  localparam int PW = 32;
  localparam int BW = 48;

  logic          core_clk = 1'b0;
  logic          reset;
  logic [NP-1:0] rx_evt_valid, rx_evt_good, tx_evt_valid;
  logic [NP*LW-1:0] rx_evt_len, tx_evt_len;
  logic          rd_req, rd_clear, overrun_clear;
  logic [2:0]    rd_port, rd_sel;
  logic          rd_valid;
  logic [BW-1:0] rd_data;
  logic [NP-1:0] evt_overrun;

  logic          s_reset, s_rx_valid, s_rx_good, s_tx_valid, s_rd_req, s_rd_clear, s_ovr_clear;
  logic [15:0]   s_rx_len, s_tx_len;
  logic [2:0]    s_rd_port, s_rd_sel;
  logic          sat_rd_valid, wrap_rd_valid;
  logic [15:0]   sat_rd_data, wrap_rd_data;
  logic          sat_ovr, wrap_ovr;

  int tests = 0;
  int fails = 0;

  always #5 core_clk = ~core_clk;

  nf_10g_stats_collector #(
    .C_NUM_PORTS(NP), .C_PKT_CNT_WIDTH(PW), .C_BYTE_CNT_WIDTH(BW),
    .C_LEN_WIDTH(LW), .C_SATURATE(0)
  ) u_dut (
    .core_clk(core_clk), .reset(reset),
    .rx_evt_valid(rx_evt_valid), .rx_evt_len(rx_evt_len), .rx_evt_good(rx_evt_good),
    .tx_evt_valid(tx_evt_valid), .tx_evt_len(tx_evt_len),
    .rd_req(rd_req), .rd_port(rd_port), .rd_sel(rd_sel), .rd_clear(rd_clear),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .evt_overrun(evt_overrun), .overrun_clear(overrun_clear)
  );

  nf_10g_stats_collector #(
    .C_NUM_PORTS(1), .C_PKT_CNT_WIDTH(16), .C_BYTE_CNT_WIDTH(16),
    .C_LEN_WIDTH(16), .C_SATURATE(1)
  ) u_sat (
    .core_clk(core_clk), .reset(s_reset),
    .rx_evt_valid(s_rx_valid), .rx_evt_len(s_rx_len), .rx_evt_good(s_rx_good),
    .tx_evt_valid(s_tx_valid), .tx_evt_len(s_tx_len),
    .rd_req(s_rd_req), .rd_port(s_rd_port), .rd_sel(s_rd_sel), .rd_clear(s_rd_clear),
    .rd_valid(sat_rd_valid), .rd_data(sat_rd_data),
    .evt_overrun(sat_ovr), .overrun_clear(s_ovr_clear)
  );

  nf_10g_stats_collector #(
    .C_NUM_PORTS(1), .C_PKT_CNT_WIDTH(16), .C_BYTE_CNT_WIDTH(16),
    .C_LEN_WIDTH(16), .C_SATURATE(0)
  ) u_wrap (
    .core_clk(core_clk), .reset(s_reset),
    .rx_evt_valid(s_rx_valid), .rx_evt_len(s_rx_len), .rx_evt_good(s_rx_good),
    .tx_evt_valid(s_tx_valid), .tx_evt_len(s_tx_len),
    .rd_req(s_rd_req), .rd_port(s_rd_port), .rd_sel(s_rd_sel), .rd_clear(s_rd_clear),
    .rd_valid(wrap_rd_valid), .rd_data(wrap_rd_data),
    .evt_overrun(wrap_ovr), .overrun_clear(s_ovr_clear)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counters per port indexed by select code, pending per source.
  longint unsigned m_cnt [NP][5];
  longint unsigned m_len [NS];
  bit              m_pend [NS];
  bit              m_good [NS];
  bit [NP-1:0]     m_ovr;
  bit              m_valid, m_live, m_rd_ok, m_v;
  longint unsigned m_data;
  int              m_ptr, m_g, m_p;

  function automatic longint unsigned m_add(input longint unsigned v, input longint unsigned inc,
                                            input int w);
    longint unsigned lim, s;
    lim = (64'd1 << w) - 64'd1;
    s   = v + inc;
    return (s > lim) ? s - lim - 64'd1 : s;
  endfunction

  always @(posedge core_clk) begin
    if (reset) begin
      for (int p = 0; p < NP; p++) for (int c = 0; c < 5; c++) m_cnt[p][c] = 0;
      for (int s = 0; s < NS; s++) m_pend[s] = 1'b0;
      m_ptr = 0; m_ovr = '0; m_valid = 1'b0; m_data = 0; m_live = 1'b1;
    end else begin
      m_valid = rd_req;
      m_rd_ok = (int'(rd_port) < NP) && (int'(rd_sel) < 5);
      if (rd_req) m_data = m_rd_ok ? m_cnt[int'(rd_port)][int'(rd_sel)] : 0;
      if (rd_req && rd_clear && m_rd_ok) m_cnt[int'(rd_port)][int'(rd_sel)] = 0;
      m_g = -1;
      for (int k = 0; k < NS; k++)
        if (m_g < 0 && m_pend[(m_ptr + k) % NS]) m_g = (m_ptr + k) % NS;
      if (m_g >= 0) begin
        m_p = m_g / 2;
        if (m_g % 2 == 1) begin
          m_cnt[m_p][3] = m_add(m_cnt[m_p][3], 1, PW);
          m_cnt[m_p][4] = m_add(m_cnt[m_p][4], m_len[m_g], BW);
        end else if (m_good[m_g]) begin
          m_cnt[m_p][0] = m_add(m_cnt[m_p][0], 1, PW);
          m_cnt[m_p][2] = m_add(m_cnt[m_p][2], m_len[m_g], BW);
        end else begin
          m_cnt[m_p][1] = m_add(m_cnt[m_p][1], 1, PW);
        end
        m_pend[m_g] = 1'b0;
        m_ptr = (m_g + 1) % NS;
      end
      if (overrun_clear) m_ovr = '0;
      for (int s = 0; s < NS; s++) begin
        m_v = (s % 2 == 1) ? tx_evt_valid[s/2] : rx_evt_valid[s/2];
        if (m_v) begin
          if (m_pend[s]) m_ovr[s/2] = 1'b1;
          else begin
            m_pend[s] = 1'b1;
            m_len[s]  = (s % 2 == 1) ? tx_evt_len[(s/2)*LW +: LW] : rx_evt_len[(s/2)*LW +: LW];
            m_good[s] = (s % 2 == 1) ? 1'b1 : rx_evt_good[s/2];
          end
        end
      end
    end
  end

  always @(negedge core_clk) begin
    if (m_live) begin
      check("model rd_valid", rd_valid, m_valid);
      if (m_valid) check("model rd_data", rd_data, m_data);
      check("model evt_overrun", evt_overrun, m_ovr);
    end
  end

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic rx_evt(input int p, input int len, input bit good);
    rx_evt_valid[p] = 1'b1;
    rx_evt_len[p*LW +: LW] = LW'(len);
    rx_evt_good[p] = good;
  endtask

  task automatic tx_evt(input int p, input int len);
    tx_evt_valid[p] = 1'b1;
    tx_evt_len[p*LW +: LW] = LW'(len);
  endtask

  task automatic no_evt();
    rx_evt_valid = '0;
    tx_evt_valid = '0;
  endtask

  task automatic all_evt(input int len);
    for (int p = 0; p < NP; p++) begin
      rx_evt(p, len, 1'b1);
      tx_evt(p, len);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One read, sampled at the next edge, checked on the following negedge.
  task automatic rd(input int port, input int sel, input bit clr, input longint unsigned exp,
                    input string name);
    rd_req = 1'b1; rd_port = 3'(port); rd_sel = 3'(sel); rd_clear = clr;
    tick();
    rd_req = 1'b0; rd_clear = 1'b0;
    @(negedge core_clk);
    check({name, " valid"}, rd_valid, 1);
    check(name, rd_data, exp);
  endtask

  task automatic rd_all(input longint unsigned pkt, input longint unsigned bad,
                        input longint unsigned bytes, input string name);
    for (int p = 0; p < NP; p++) begin
      rd(p, 0, 1'b0, pkt, name);
      rd(p, 1, 1'b0, bad, name);
      rd(p, 2, 1'b0, bytes, name);
      rd(p, 3, 1'b0, pkt, name);
      rd(p, 4, 1'b0, bytes, name);
    end
  endtask

  task automatic s_rd(input int sel, input longint unsigned exp_sat, input longint unsigned exp_wrap,
                      input string name);
    s_rd_req = 1'b1; s_rd_sel = 3'(sel);
    tick();
    s_rd_req = 1'b0;
    @(negedge core_clk);
    check({name, " sat valid"}, sat_rd_valid, 1);
    check({name, " sat"}, sat_rd_data, exp_sat);
    check({name, " wrap"}, wrap_rd_data, exp_wrap);
  endtask

  initial begin
    reset = 1'b1; s_reset = 1'b1;
    rx_evt_valid = '0; rx_evt_good = '0; tx_evt_valid = '0; rx_evt_len = '0; tx_evt_len = '0;
    rd_req = 1'b0; rd_clear = 1'b0; rd_port = '0; rd_sel = '0; overrun_clear = 1'b0;
    s_rx_valid = 1'b0; s_rx_good = 1'b1; s_tx_valid = 1'b0; s_rx_len = '0; s_tx_len = '0;
    s_rd_req = 1'b0; s_rd_clear = 1'b0; s_rd_port = '0; s_rd_sel = '0; s_ovr_clear = 1'b0;
    repeat (2) tick();
    reset = 1'b0; s_reset = 1'b0;
    @(negedge core_clk);
    check("reset rd_valid", rd_valid, 0);
    check("reset rd_data", rd_data, 0);
    check("reset evt_overrun", evt_overrun, 0);
    rd(2, 2, 1'b0, 0, "reset rx_bytes");
    rd(5, 0, 1'b0, 0, "bad port");
    rd(0, 5, 1'b0, 0, "bad sel");

    // Single RX good frame on port 1: invisible one edge after capture, visible after.
    rx_evt(1, 64, 1'b1);
    tick();
    no_evt();
    rd(1, 2, 1'b0, 0, "rx1 bytes before write");
    rd(1, 2, 1'b0, 64, "rx1 bytes");
    rd(1, 0, 1'b0, 1, "rx1 good");
    rd(1, 1, 1'b0, 0, "rx1 bad");
    rd(1, 3, 1'b0, 0, "rx1 tx pkts");
    rd(0, 2, 1'b0, 0, "rx0 bytes");

    // All 8 sources at once: source j-1 must still read 0 at edge j, all done by edge 8.
    do_reset();
    all_evt(100);
    tick();
    no_evt();
    for (int j = 1; j <= NS; j++) rd((j-1)/2, ((j-1)%2 == 1) ? 3 : 0, 1'b0, 0, "rr slot");
    rd_all(1, 0, 100, "rr after");

    // Overrun: RX0 wins first, so the second TX0 strobe finds TX0 still pending.
    do_reset();
    rx_evt(0, 70, 1'b1);
    tx_evt(0, 80);
    tick();
    no_evt();
    tx_evt(0, 90);
    tick();
    no_evt();
    @(negedge core_clk);
    check("overrun set", evt_overrun, 4'b0001);
    tick();
    rd(0, 3, 1'b0, 1, "ovr tx pkts");
    rd(0, 4, 1'b0, 80, "ovr tx bytes kept old");
    rd(0, 2, 1'b0, 70, "ovr rx bytes");
    overrun_clear = 1'b1;
    tick();
    overrun_clear = 1'b0;
    @(negedge core_clk);
    check("overrun cleared", evt_overrun, 4'b0000);

    // Port 3: set beats clear, then a strobe on the granted source is accepted.
    rx_evt(3, 10, 1'b0);
    tx_evt(3, 10);
    tick();
    rx_evt_valid = '0;
    tx_evt(3, 20);
    overrun_clear = 1'b1;
    tick();
    overrun_clear = 1'b0;
    tx_evt(3, 30);
    tick();
    no_evt();
    @(negedge core_clk);
    check("set beats clear", evt_overrun, 4'b1000);
    tick();
    rd(3, 3, 1'b0, 2, "reload tx pkts");
    rd(3, 4, 1'b0, 40, "reload tx bytes");
    rd(3, 1, 1'b0, 1, "rx bad pkts");
    rd(3, 2, 1'b0, 0, "bad frame no bytes");

    // Clear-on-read racing a TX update on the same counter.
    do_reset();
    tx_evt(2, 500);
    tick();
    no_evt();
    repeat (2) tick();
    tx_evt(2, 60);
    tick();
    no_evt();
    rd(2, 4, 1'b1, 500, "race clr read");
    rd(2, 4, 1'b0, 60, "race after");
    rd(2, 3, 1'b1, 2, "clr tx pkts");
    rd(2, 3, 1'b0, 0, "tx pkts cleared");

    // Reset in the middle of a burst with overruns and a read in flight.
    all_evt(100);
    tick();
    tick();
    no_evt();
    reset = 1'b1;
    rd_req = 1'b1; rd_port = 3'd0; rd_sel = 3'd0;
    tick();
    reset = 1'b0; rd_req = 1'b0;
    @(negedge core_clk);
    check("mid reset rd_valid", rd_valid, 0);
    check("mid reset overrun", evt_overrun, 0);
    repeat (12) tick();
    rd_all(0, 0, 0, "after mid reset");

    // Wrap vs saturate on 16-bit byte counters: 4095 x 16 = 0xFFF0, then +32.
    for (int i = 0; i < 4095; i++) begin
      s_rx_valid = 1'b1; s_rx_len = 16'd16;
      tick();
      s_rx_valid = 1'b0;
      tick();
    end
    tick();
    s_rd(2, 64'hFFF0, 64'hFFF0, "preload bytes");
    s_rx_valid = 1'b1; s_rx_len = 16'd32;
    tick();
    s_rx_valid = 1'b0;
    repeat (2) tick();
    s_rd(2, 64'hFFFF, 64'h0010, "overflow bytes");
    s_rd(0, 64'h1000, 64'h1000, "overflow pkts");
    check("sat no overrun", sat_ovr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
